// File: rtl/rgb_csc_writer.sv
// rgb_csc_writer
//   Converts upsampled Y/U/V pixels to 8-bit RGB in fixed point, packs each
//   pixel pair into three 16-bit words and writes them to consecutive SRAM
//   words starting at RGB_BASE. Writes happen only in cycles where the SRAM
//   write port is granted to this block.
//
// Ports
//   Clock_50        system clock, rising edge
//   Resetn          asynchronous active-low reset
//   start           one-cycle pulse, starts a frame when idle
//   in_valid        upstream pixel valid
//   in_ready        pixel accepted this cycle when in_valid & in_ready
//   Y, U, V         unsigned 8-bit samples
//   wr_grant        SRAM write port available this cycle
//   SRAM_address    registered write address
//   SRAM_write_data registered write data
//   SRAM_we_n       registered active-low write strobe
//   busy            frame in progress (running or draining)
//   done            one-cycle pulse after the last word is written
module rgb_csc_writer #(
  parameter int RGB_BASE   = 146944,
  parameter int NUM_PIXELS = 76800,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        Clock_50,
  input  logic        Resetn,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  Y,
  input  logic [7:0]  U,
  input  logic [7:0]  V,
  input  logic        wr_grant,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic        busy,
  output logic        done
);

  localparam int NUM_WORDS = 3 * NUM_PIXELS / 2;
  localparam int PW        = $clog2(FIFO_DEPTH);
  localparam int CW        = $clog2(FIFO_DEPTH + 1);
  localparam int AW        = $clog2(NUM_PIXELS + 1);
  localparam int WW        = $clog2(NUM_WORDS + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t state_reg, state_next;

  logic [AW-1:0] acc_cnt_reg;
  logic [WW-1:0] wr_cnt_reg;
  logic          phase_reg;       // 1 when stage 3 holds the odd pixel of a pair

  logic                s1_valid_reg, s2_valid_reg, s3_valid_reg;
  logic signed [8:0]   y_s1_reg, u_s1_reg, v_s1_reg;
  logic signed [31:0]  r_s2_reg, g_s2_reg, b_s2_reg;
  logic [7:0]          r_s3_reg, g_s3_reg, b_s3_reg;
  logic [7:0]          r_hold_reg, g_hold_reg, b_hold_reg;

  logic [15:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;

  logic [17:0]   wr_addr_reg;     // address the next popped word goes to

  logic frame_start, pipe_busy, adv, xfer, push, pop;
  logic signed [31:0] y_ext, u_ext, v_ext;
  logic signed [31:0] r_prod, g_prod, b_prod;
  logic [15:0]   push_word [3];
  logic [PW-1:0] push_ptr  [3];

  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= FIFO_DEPTH) s = s - FIFO_DEPTH;
    return PW'(s);
  endfunction

  // Drop the 16 fraction bits, then saturate to 0..255.
  function automatic logic [7:0] clip8(input logic signed [31:0] p);
    logic signed [31:0] s;
    s = p >>> 16;
    if (s < 0)
      return 8'd0;
    else if (s > 32'sd255)
      return 8'd255;
    else
      return s[7:0];
  endfunction

  assign frame_start = (state_reg == S_IDLE) && start;
  assign pipe_busy   = s1_valid_reg || s2_valid_reg || s3_valid_reg;
  // Leave room for the three words a completed pair pushes at once.
  assign adv         = ((state_reg == S_RUN) || pipe_busy) &&
                       (count_reg <= CW'(FIFO_DEPTH - 3));
  assign in_ready    = (state_reg == S_RUN) && adv &&
                       (acc_cnt_reg < AW'(NUM_PIXELS));
  assign xfer        = in_valid && in_ready;
  assign push        = adv && s3_valid_reg && phase_reg;
  assign pop         = (count_reg != '0) && wr_grant;

  assign busy = (state_reg == S_RUN) || (state_reg == S_DRAIN);
  assign done = (state_reg == S_DONE);

  assign y_ext = {{23{y_s1_reg[8]}}, y_s1_reg};
  assign u_ext = {{23{u_s1_reg[8]}}, u_s1_reg};
  assign v_ext = {{23{v_s1_reg[8]}}, v_s1_reg};

  assign r_prod = 32'sd76284 * y_ext + 32'sd104595 * v_ext;
  assign g_prod = 32'sd76284 * y_ext - 32'sd25624 * u_ext - 32'sd53281 * v_ext;
  assign b_prod = 32'sd76284 * y_ext + 32'sd132251 * u_ext;

  assign push_word[0] = {r_hold_reg, g_hold_reg};
  assign push_word[1] = {b_hold_reg, r_s3_reg};
  assign push_word[2] = {g_s3_reg, b_s3_reg};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_push_ptr
      assign push_ptr[gi] = ptr_add(wr_ptr_reg, gi);
    end
  endgenerate

  // ---------------- control FSM ----------------
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) state_reg <= S_IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_RUN;
      S_RUN:   if (acc_cnt_reg == AW'(NUM_PIXELS)) state_next = S_DRAIN;
      S_DRAIN: if (wr_cnt_reg == WW'(NUM_WORDS)) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------- frame counters ----------------
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      acc_cnt_reg <= '0;
      wr_cnt_reg  <= '0;
      phase_reg   <= 1'b0;
    end else if (frame_start) begin
      acc_cnt_reg <= '0;
      wr_cnt_reg  <= '0;
      phase_reg   <= 1'b0;
    end else begin
      if (xfer) acc_cnt_reg <= acc_cnt_reg + 1'b1;
      if (pop)  wr_cnt_reg  <= wr_cnt_reg + 1'b1;
      if (adv && s3_valid_reg) phase_reg <= ~phase_reg;
    end
  end

  // ---------------- conversion pipeline ----------------
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      s3_valid_reg <= 1'b0;
      y_s1_reg     <= '0;
      u_s1_reg     <= '0;
      v_s1_reg     <= '0;
      r_s2_reg     <= '0;
      g_s2_reg     <= '0;
      b_s2_reg     <= '0;
      r_s3_reg     <= '0;
      g_s3_reg     <= '0;
      b_s3_reg     <= '0;
      r_hold_reg   <= '0;
      g_hold_reg   <= '0;
      b_hold_reg   <= '0;
    end else if (frame_start) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      s3_valid_reg <= 1'b0;
    end else if (adv) begin
      s1_valid_reg <= xfer;
      y_s1_reg     <= $signed({1'b0, Y}) - 9'sd16;
      u_s1_reg     <= $signed({1'b0, U}) - 9'sd128;
      v_s1_reg     <= $signed({1'b0, V}) - 9'sd128;
      s2_valid_reg <= s1_valid_reg;
      r_s2_reg     <= r_prod;
      g_s2_reg     <= g_prod;
      b_s2_reg     <= b_prod;
      s3_valid_reg <= s2_valid_reg;
      r_s3_reg     <= clip8(r_s2_reg);
      g_s3_reg     <= clip8(g_s2_reg);
      b_s3_reg     <= clip8(b_s2_reg);
      // Even pixel leaves stage 3: keep it until its odd partner arrives.
      if (s3_valid_reg && !phase_reg) begin
        r_hold_reg <= r_s3_reg;
        g_hold_reg <= g_s3_reg;
        b_hold_reg <= b_s3_reg;
      end
    end
  end

  // ---------------- word FIFO ----------------
  always_ff @(posedge Clock_50) begin
    if (push) begin
      for (int k = 0; k < 3; k++) fifo_mem[push_ptr[k]] <= push_word[k];
    end
  end

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (frame_start) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= ptr_add(wr_ptr_reg, 3);
      if (pop)  rd_ptr_reg <= ptr_add(rd_ptr_reg, 1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(3);
        2'b01:   count_reg <= count_reg - CW'(1);
        2'b11:   count_reg <= count_reg + CW'(2);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ---------------- SRAM write port ----------------
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      SRAM_we_n       <= 1'b1;
      SRAM_address    <= 18'(RGB_BASE);
      SRAM_write_data <= '0;
      wr_addr_reg     <= 18'(RGB_BASE);
    end else begin
      SRAM_we_n <= ~pop;
      if (pop) begin
        SRAM_address    <= wr_addr_reg;
        SRAM_write_data <= fifo_mem[rd_ptr_reg];
        wr_addr_reg     <= wr_addr_reg + 18'd1;
      end else if (frame_start) begin
        wr_addr_reg <= 18'(RGB_BASE);
      end
    end
  end

endmodule

// File: tb/tb_rgb_csc_writer.sv
module tb_rgb_csc_writer;

  localparam int RGB_BASE = 146944;
  localparam int NP       = 48;
  localparam int FD       = 8;
  localparam int NW       = 3 * NP / 2;

  logic        Clock_50 = 1'b0;
  logic        Resetn;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  Y, U, V;
  logic        wr_grant;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic        busy;
  logic        done;

  always #5 Clock_50 = ~Clock_50;

  rgb_csc_writer #(
    .RGB_BASE  (RGB_BASE),
    .NUM_PIXELS(NP),
    .FIFO_DEPTH(FD)
  ) dut (
    .Clock_50       (Clock_50),
    .Resetn         (Resetn),
    .start          (start),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .Y              (Y),
    .U              (U),
    .V              (V),
    .wr_grant       (wr_grant),
    .SRAM_address   (SRAM_address),
    .SRAM_write_data(SRAM_write_data),
    .SRAM_we_n      (SRAM_we_n),
    .busy           (busy),
    .done           (done)
  );

  int checks = 0;
  int errors = 0;

  logic [33:0] exp_q [$];   // {address, data} in expected write order
  logic [23:0] pix_q [$];   // converted {R,G,B} waiting for a partner
  int          word_idx;
  int          acc;
  int          wr_seen;
  int          done_seen;
  bit          prev_we_low = 1'b0;
  logic [33:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference conversion straight from the colour equations.
  function automatic int clamp_byte(input int x);
    int s;
    s = x >>> 16;
    if (s < 0) return 0;
    if (s > 255) return 255;
    return s;
  endfunction

  function automatic logic [23:0] model_rgb(input int yi, input int ui, input int vi);
    int y, u, v, r, g, b;
    y = yi - 16;
    u = ui - 128;
    v = vi - 128;
    r = clamp_byte(76284 * y + 104595 * v);
    g = clamp_byte(76284 * y - 25624 * u - 53281 * v);
    b = clamp_byte(76284 * y + 132251 * u);
    return {r[7:0], g[7:0], b[7:0]};
  endfunction

  task automatic model_accept(input int yi, input int ui, input int vi);
    logic [23:0] a, b;
    pix_q.push_back(model_rgb(yi, ui, vi));
    if (pix_q.size() == 2) begin
      a = pix_q.pop_front();
      b = pix_q.pop_front();
      exp_q.push_back({18'(RGB_BASE + word_idx),     a[23:8]});
      exp_q.push_back({18'(RGB_BASE + word_idx + 1), {a[7:0], b[23:16]}});
      exp_q.push_back({18'(RGB_BASE + word_idx + 2), b[15:0]});
      word_idx += 3;
    end
  endtask

  // Monitor: every strobed write must match the head of the scoreboard.
  always @(negedge Clock_50) begin
    if (Resetn === 1'b1) begin
      if (done === 1'b1) begin
        done_seen++;
        check("done_after_last_write_busy_low", {30'd0, prev_we_low, busy}, 32'd2);
      end
      if (SRAM_we_n === 1'b0) begin
        wr_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual addr=%0d data=0x%0h required=no write",
                   SRAM_address, SRAM_write_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("write_address", {14'd0, SRAM_address}, {14'd0, mon_e[33:16]});
          check("write_data", {16'd0, SRAM_write_data}, {16'd0, mon_e[15:0]});
        end
      end
      prev_we_low = (SRAM_we_n === 1'b0);
    end else begin
      prev_we_low = 1'b0;
    end
  end

  // One clock cycle of stimulus, starting and ending at a falling edge.
  task automatic drive_cycle(input bit v, input bit g, input bit st,
                             input int yi, input int ui, input int vi);
    bit xfer;
    in_valid = v;
    wr_grant = g;
    start    = st;
    Y        = 8'(yi);
    U        = 8'(ui);
    V        = 8'(vi);
    xfer     = v && (in_ready === 1'b1);
    if (xfer) begin
      model_accept(yi, ui, vi);
      acc++;
    end
    @(negedge Clock_50);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_we_n"}, {31'd0, SRAM_we_n}, 32'd1);
    check({tag, "_address"}, {14'd0, SRAM_address}, RGB_BASE);
    check({tag, "_data"}, {16'd0, SRAM_write_data}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  task automatic run_frame(input int abort_at, input bit directed,
                           input bit rand_grant, input bit stall_restart);
    int  dy [4] = '{16, 255, 16, 16};
    int  du [4] = '{128, 128, 128, 128};
    int  dv [4] = '{128, 128, 255, 255};
    int  cyc;
    bit  stalled, restarted, v, g, st;
    int  yi, ui, vi;
    word_idx  = 0;
    acc       = 0;
    wr_seen   = 0;
    done_seen = 0;
    stalled   = 0;
    restarted = 0;
    pix_q.delete();

    drive_cycle(1'b0, 1'b1, 1'b1, 0, 0, 0);
    check("first_in_ready_after_start", {31'd0, in_ready}, 32'd1);
    check("busy_after_start", {31'd0, busy}, 32'd1);

    cyc = 0;
    while (acc < NP && cyc < 2000) begin
      cyc++;
      if (abort_at >= 0 && acc == abort_at) begin
        in_valid = 1'b0;
        start    = 1'b0;
        #2 Resetn = 1'b0;
        #1 check_reset_outputs("abort_reset");
        repeat (3) begin
          @(negedge Clock_50);
          check("we_n_during_reset", {31'd0, SRAM_we_n}, 32'd1);
        end
        exp_q.delete();
        pix_q.delete();
        Resetn = 1'b1;
        repeat (6) drive_cycle(1'b0, 1'b1, 1'b0, 0, 0, 0);
        return;
      end
      if (stall_restart && !stalled && acc >= 16) begin
        stalled = 1;
        for (int i = 0; i < 20; i++) begin
          drive_cycle(1'b1, 1'b0, 1'b0, $urandom_range(0, 255),
                      $urandom_range(0, 255), $urandom_range(0, 255));
          check("stall_we_n_high", {31'd0, SRAM_we_n}, 32'd1);
        end
        check("stall_in_ready_low", {31'd0, in_ready}, 32'd0);
        continue;
      end
      st = 1'b0;
      if (stall_restart && !restarted && acc >= 30) begin
        restarted = 1;
        st = 1'b1;
      end
      if (directed && acc < 4) begin
        v  = 1'b1;
        yi = dy[acc];
        ui = du[acc];
        vi = dv[acc];
      end else begin
        v  = ($urandom_range(0, 3) != 0);
        yi = $urandom_range(0, 255);
        ui = $urandom_range(0, 255);
        vi = $urandom_range(0, 255);
      end
      g = rand_grant ? ($urandom_range(0, 3) != 0) : 1'b1;
      drive_cycle(v, g, st, yi, ui, vi);
    end
    if (acc < NP) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=%0d pixels required=%0d", acc, NP);
    end

    cyc = 0;
    while (done_seen == 0 && cyc < 3000) begin
      cyc++;
      g = rand_grant ? ($urandom_range(0, 3) != 0) : 1'b1;
      drive_cycle(1'b0, g, 1'b0, 0, 0, 0);
    end
    repeat (5) drive_cycle(1'b0, 1'b1, 1'b0, 0, 0, 0);
    check("done_pulse_count", done_seen, 32'd1);
    check("frame_write_count", wr_seen, NW);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    check("idle_busy_low", {31'd0, busy}, 32'd0);
    check("idle_in_ready_low", {31'd0, in_ready}, 32'd0);
    $display("frame done: pixels=%0d writes=%0d", acc, wr_seen);
  endtask

  initial begin
    Resetn   = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    wr_grant = 1'b0;
    Y        = '0;
    U        = '0;
    V        = '0;
    repeat (3) @(negedge Clock_50);
    check_reset_outputs("power_on_reset");
    Resetn = 1'b1;
    @(negedge Clock_50);

    run_frame(-1, 1'b1, 1'b0, 1'b0);   // directed pairs, grant always on
    run_frame(-1, 1'b0, 1'b1, 1'b1);   // random grant, stall, stray start
    run_frame(10, 1'b0, 1'b0, 1'b0);   // abandoned by reset
    run_frame(-1, 1'b1, 1'b1, 1'b0);   // fresh frame after reset

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rgb_csc_writer.md
# rgb_csc_writer

Final colour-space stage of the milestone 1 decoder. It accepts upsampled Y/U/V pixels, converts each to 8-bit RGB in fixed point, packs every pixel pair into three 16-bit words and writes them sequentially to the RGB region of external SRAM (words 146944..262143). Its only consumer is the SRAM write port, which the top level grants to this block by cycle-level arbitration.

## Interface
- RGB_BASE, 146944, first SRAM word address written
- NUM_PIXELS, 76800, pixels per frame (320x240); must be even
- FIFO_DEPTH, 8, output word FIFO depth
- Clock_50  in  1  system clock, all logic on rising edge
- Resetn  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a frame when idle
- in_valid  in  1  upstream pixel valid
- in_ready  out  1  block accepts pixel this cycle (transfer = in_valid & in_ready)
- Y, U, V  in  8 each  unsigned pixel samples
- wr_grant  in  1  SRAM write port available this cycle
- SRAM_address  out  18  registered write address
- SRAM_write_data  out  16  registered write data
- SRAM_we_n  out  1  registered, active-low write strobe
- busy  out  1  high in S_RUN/S_DRAIN
- done  out  1  one-cycle pulse when the last word is written

## Operation
- States: S_IDLE -> (start) S_RUN -> (NUM_PIXELS accepted) S_DRAIN -> (all 3*NUM_PIXELS/2 words written) S_DONE -> S_IDLE. start outside S_IDLE is ignored.
- Entering S_RUN clears the pixel count, the pair-phase bit and the FIFO, and sets the write address to RGB_BASE.
- Pipeline, three stages, advancing together on enable `adv`:
  - Stage 1: y = Y-16, u = U-128, v = V-128 (signed).
  - Stage 2: 32-bit signed products: R = 76284y + 104595v; G = 76284y - 25624u - 53281v; B = 76284y + 132251u.
  - Stage 3: arithmetic shift right by 16, then clip: <0 -> 0, >255 -> 255.
- Pairing: stage-3 output of an even pixel is held (R0,G0,B0). On the odd pixel, push {R0,G0}, {B0,R1}, {G1,B1} into the FIFO in that order in a single cycle.
- adv = (state==S_RUN or pipeline non-empty) & (registered FIFO count <= FIFO_DEPTH-3). in_ready = (state==S_RUN) & adv & (accepted < NUM_PIXELS).
- Write: when the FIFO is non-empty and wr_grant=1, pop one word. On the next cycle drive SRAM_we_n=0, SRAM_address=current address, SRAM_write_data=word, then increment the address. Otherwise SRAM_we_n=1, and address/data hold their values.
- At most one write per cycle. There is never a write outside RGB_BASE..RGB_BASE+3*NUM_PIXELS/2-1, so the address never wraps.

## Timing
- Reset values: in_ready=0, SRAM_we_n=1, SRAM_address=RGB_BASE, SRAM_write_data=0, busy=0, done=0, state S_IDLE, FIFO empty.
- The first in_ready is one cycle after start.
- Pixel latency: the odd pixel is accepted at cycle t; its 3 words are in the FIFO after edge t+3. With wr_grant high they appear as we_n-low cycles t+4, t+5, t+6 (the first word of an idle pipeline).
- Sustained throughput is 2 pixels per 3 cycles, limited by the write port. in_ready drops whenever the FIFO count is >= 6.
- Simultaneous push and pop in the same cycle: the count changes by +3-1.
- done is high for exactly the cycle after the final we_n-low cycle. busy falls in that same cycle.
- Resetn asserted mid-frame: all outputs return to reset values immediately (asynchronously). No further writes occur. The frame is abandoned.
- wr_grant low: the pipeline keeps filling until the FIFO threshold, then stalls. No pixel is lost or duplicated.

## Test plan
- Pixel (Y=16,U=128,V=128) then (Y=255,U=128,V=128) -> words 0x0000 @146944, 0x00FF @146945, 0xFFFF @146946.
- Pixel pair both (Y=16,U=128,V=255) -> R=202, G=0 (negative clip), B=0. Words 0xCA00, 0x00CA, 0x0000.
- Full frame of 76800 random pixels checked against a software model -> 115200 writes, each address 146944..262143 written exactly once, done pulses once, top state returns to idle.
- wr_grant low for 20 cycles mid-frame with in_valid high -> in_ready drops once the FIFO count is >= 6, SRAM_we_n stays 1, no data corruption after grant resumes.
- Resetn pulsed low after 100 pixels, then a new start -> SRAM_we_n=1 during reset, and the next frame's first write goes to 146944 with correct data.
- start pulsed during S_RUN -> ignored; address sequence is uninterrupted.
